// File: rtl/axis128_frame_checker.sv
// 128-bit AXI-Stream frame checker: forwards beats through a 2-entry skid buffer and output register,
// reports per-frame length/keep/runt/oversize status, and keeps good/bad frame counters.
module axis128_frame_checker #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 9600
) (
  input  logic         axis_uclk,
  input  logic         Rst_n,
  input  logic [127:0] rx_axis_tdata,
  input  logic [15:0]  rx_axis_tkeep,
  input  logic         rx_axis_tvalid,
  input  logic         rx_axis_tlast,
  output logic         rx_axis_tready,
  output logic [127:0] tx_axis_tdata,
  output logic [15:0]  tx_axis_tkeep,
  output logic         tx_axis_tvalid,
  output logic         tx_axis_tlast,
  output logic         tx_axis_tuser,
  input  logic         tx_axis_tready,
  input  logic         CntClr,
  output logic         FrmDone,
  output logic [15:0]  FrmLen,
  output logic [2:0]   FrmErr,
  output logic [31:0]  GoodFrm_Cnt,
  output logic [31:0]  BadFrm_Cnt
);

  typedef enum logic {ST_IDLE, ST_IN_FRAME} state_t;

  localparam int          BW    = 146;
  localparam logic [31:0] MIN_L = MIN_FRAME_BYTES;
  localparam logic [31:0] MAX_L = MAX_FRAME_BYTES;

  state_t          state_q, state_d;
  logic [BW-1:0]   out_q, out_d, e0_q, e0_d, e1_q, e1_d;
  logic            out_vld_q, out_vld_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic [15:0]     len_q, len_d;
  logic            kerr_q, kerr_d;
  logic            done_q, done_d;
  logic [15:0]     frm_len_q, frm_len_d;
  logic [2:0]      frm_err_q, frm_err_d;
  logic [31:0]     good_q, good_d, bad_q, bad_d;

  logic            acc, out_free, push, pop, sop;
  logic [4:0]      pcnt;
  logic [16:0]     sum;
  logic [15:0]     len_new;
  logic            kerr_new, runt, over;
  logic [2:0]      err_new;
  logic [BW-1:0]   in_beat;

  function automatic logic [4:0] popcnt(input logic [15:0] k);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, k[i]};
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    e0_d      = e0_q;
    e1_d      = e1_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    kerr_d    = kerr_q;
    done_d    = 1'b0;
    frm_len_d = frm_len_q;
    frm_err_d = frm_err_q;
    good_d    = good_q;
    bad_d     = bad_q;
    push      = 1'b0;
    pop       = 1'b0;

    // Status of the frame as it stands including the beat being offered now.
    acc      = rx_axis_tvalid && rdy_q;
    sop      = (state_q == ST_IDLE);
    pcnt     = popcnt(rx_axis_tkeep);
    sum      = (sop ? 17'd0 : {1'b0, len_q}) + {12'd0, pcnt};
    len_new  = sum[16] ? 16'hFFFF : sum[15:0];
    kerr_new = (!sop && kerr_q) |
               (rx_axis_tlast ? (rx_axis_tkeep == 16'h0000) : (rx_axis_tkeep != 16'hFFFF));
    runt     = {16'd0, len_new} < MIN_L;
    over     = ({16'd0, len_new} > MAX_L) || (len_new == 16'hFFFF);
    err_new  = {over, runt, kerr_new};
    in_beat  = {rx_axis_tdata, rx_axis_tkeep, rx_axis_tlast, rx_axis_tlast & (|err_new)};

    // Skid entries always drain into the output register before new input, preserving order.
    out_free = !out_vld_q || tx_axis_tready;
    if (out_free) begin
      if (cnt_q != 2'd0) begin
        out_d     = e0_q;
        out_vld_d = 1'b1;
        pop       = 1'b1;
        push      = acc;
      end else if (acc) begin
        out_d     = in_beat;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else begin
      push = acc;
    end

    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = in_beat;
        else               e1_d = in_beat;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) e0_d = in_beat;
        else begin
          e0_d = e1_q;
          e1_d = in_beat;
        end
      end
      default: ;
    endcase
    rdy_d = (cnt_d != 2'd2);

    if (acc) begin
      len_d   = len_new;
      kerr_d  = kerr_new;
      state_d = rx_axis_tlast ? ST_IDLE : ST_IN_FRAME;
      if (rx_axis_tlast) begin
        done_d    = 1'b1;
        frm_len_d = len_new;
        frm_err_d = err_new;
      end
    end

    // Counters follow the registered status pulse; clear wins over a same-cycle increment.
    if (CntClr) begin
      good_d = '0;
      bad_d  = '0;
    end else if (done_q) begin
      if (frm_err_q == 3'b000) good_d = good_q + 32'd1;
      else                     bad_d  = bad_q + 32'd1;
    end
  end

  always_ff @(posedge axis_uclk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      e0_q      <= '0;
      e1_q      <= '0;
      cnt_q     <= 2'd0;
      rdy_q     <= 1'b0;
      len_q     <= '0;
      kerr_q    <= 1'b0;
      done_q    <= 1'b0;
      frm_len_q <= '0;
      frm_err_q <= '0;
      good_q    <= '0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      e0_q      <= e0_d;
      e1_q      <= e1_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      len_q     <= len_d;
      kerr_q    <= kerr_d;
      done_q    <= done_d;
      frm_len_q <= frm_len_d;
      frm_err_q <= frm_err_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
    end
  end

  assign rx_axis_tready = rdy_q;
  assign tx_axis_tdata  = out_q[145:18];
  assign tx_axis_tkeep  = out_q[17:2];
  assign tx_axis_tlast  = out_q[1];
  assign tx_axis_tuser  = out_q[0];
  assign tx_axis_tvalid = out_vld_q;
  assign FrmDone        = done_q;
  assign FrmLen         = frm_len_q;
  assign FrmErr         = frm_err_q;
  assign GoodFrm_Cnt    = good_q;
  assign BadFrm_Cnt     = bad_q;

endmodule

// File: tb/tb_axis128_frame_checker.sv
// Bench for axis128_frame_checker: vector table, random frames with random back-pressure
// against a frame-level reference model, plus counter-clear and mid-frame reset sequences.
module tb_axis128_frame_checker;

  logic         axis_uclk = 1'b0;
  logic         Rst_n = 1'b0;
  logic [127:0] rx_axis_tdata = '0;
  logic [15:0]  rx_axis_tkeep = '0;
  logic         rx_axis_tvalid = 1'b0;
  logic         rx_axis_tlast = 1'b0;
  logic         rx_axis_tready;
  logic [127:0] tx_axis_tdata;
  logic [15:0]  tx_axis_tkeep;
  logic         tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser;
  logic         tx_axis_tready = 1'b0;
  logic         CntClr = 1'b0;
  logic         FrmDone;
  logic [15:0]  FrmLen;
  logic [2:0]   FrmErr;
  logic [31:0]  GoodFrm_Cnt, BadFrm_Cnt;

  axis128_frame_checker #(.MIN_FRAME_BYTES(64), .MAX_FRAME_BYTES(9600)) dut (
    .axis_uclk(axis_uclk), .Rst_n(Rst_n),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tlast(rx_axis_tlast),
    .rx_axis_tready(rx_axis_tready),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tuser(tx_axis_tuser), .tx_axis_tready(tx_axis_tready),
    .CntClr(CntClr), .FrmDone(FrmDone), .FrmLen(FrmLen), .FrmErr(FrmErr),
    .GoodFrm_Cnt(GoodFrm_Cnt), .BadFrm_Cnt(BadFrm_Cnt)
  );

  always #5 axis_uclk = ~axis_uclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge axis_uclk) cyc <= cyc + 1;

  logic [145:0] exp_q[$];
  logic [18:0]  stat_q[$];
  int           cyc_q[$];
  logic [15:0]  frame_keep [0:4199];
  int           good_m = 0;
  int           bad_m  = 0;
  bit           rdy_rand = 1'b0;
  logic         rdy_fixed = 1'b1;

  typedef struct {
    int          nb;
    int          bad_idx;
    logic [15:0] bad_keep;
    logic [15:0] last_keep;
    logic [15:0] exp_len;
    logic [2:0]  exp_err;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: total bytes, keep rule, and length bounds from the byte count.
  function automatic logic [18:0] ref_status(input int nb);
    int          sum = 0;
    bit          ke  = 1'b0;
    logic [15:0] len;
    for (int i = 0; i < nb; i++) begin
      sum += $countones(frame_keep[i]);
      if (i < nb - 1 && frame_keep[i] != 16'hFFFF) ke = 1'b1;
    end
    if (frame_keep[nb-1] == 16'h0000) ke = 1'b1;
    len = (sum > 65535) ? 16'hFFFF : 16'(sum);
    return {len, sum > 9600, sum < 64, ke};
  endfunction

  initial forever begin
    @(posedge axis_uclk);
    #1;
    tx_axis_tready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_fixed;
  end

  // Output monitor: scoreboard order, hold-while-stalled, frame status timing.
  logic [145:0] mon_cur, mon_prev, mon_exp;
  logic [18:0]  mon_s;
  int           mon_c;
  bit           prev_stall = 1'b0;
  initial forever begin
    @(negedge axis_uclk);
    mon_cur = {tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tuser};
    if (!Rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_vld", tx_axis_tvalid, 1);
        chk("hold_beat", mon_cur, mon_prev);
      end
      if (tx_axis_tvalid && tx_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: got %0h, expected none", mon_cur);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("beat", mon_cur, mon_exp);
        end
      end
      if (FrmDone) begin
        if (stat_q.size() == 0 || cyc_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got FrmDone=1 len=%0d, expected no pulse", FrmLen);
        end else begin
          mon_s = stat_q.pop_front();
          mon_c = cyc_q.pop_front();
          chk("frm_len", FrmLen, mon_s[18:3]);
          chk("frm_err", FrmErr, mon_s[2:0]);
          chk("done_cycle", cyc, mon_c);
        end
      end
      prev_stall = tx_axis_tvalid && !tx_axis_tready;
      mon_prev   = mon_cur;
    end
  end

  task automatic summary_and_fatal(input string why);
    n_tests++; n_fail++;
    $display("FAIL %s: got timeout, expected progress", why);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "aborted");
  endtask

  // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l,
                           input logic u, input int gap);
    bit done = 1'b0;
    repeat (gap) begin
      rx_axis_tvalid = 1'b0;
      @(posedge axis_uclk); #1;
    end
    rx_axis_tdata = d; rx_axis_tkeep = k; rx_axis_tlast = l; rx_axis_tvalid = 1'b1;
    for (int w = 0; w < 2000 && !done; w++) begin
      @(negedge axis_uclk);
      if (rx_axis_tready) begin
        exp_q.push_back({d, k, l, u});
        if (l) cyc_q.push_back(cyc + 1);
        done = 1'b1;
      end
      @(posedge axis_uclk); #1;
    end
    rx_axis_tvalid = 1'b0;
    if (!done) summary_and_fatal("rx_accept");
  endtask

  task automatic send_frame(input int nb, input logic [15:0] elen, input logic [2:0] eerr,
                            input bit gaps);
    stat_q.push_back({elen, eerr});
    if (eerr == 3'b000) good_m++; else bad_m++;
    for (int i = 0; i < nb; i++)
      send_beat({$urandom, $urandom, $urandom, $urandom}, frame_keep[i], i == nb - 1,
                (i == nb - 1) && (|eerr),
                (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
  endtask

  task automatic drain();
    for (int w = 0; w < 30000 && (exp_q.size() != 0 || stat_q.size() != 0); w++)
      @(posedge axis_uclk);
    if (exp_q.size() != 0 || stat_q.size() != 0) summary_and_fatal("drain");
    repeat (3) @(posedge axis_uclk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_good_cnt"}, GoodFrm_Cnt, good_m);
    chk({tag, "_bad_cnt"}, BadFrm_Cnt, bad_m);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tvalid"}, tx_axis_tvalid, 0);
    chk({tag, "_tlast"}, tx_axis_tlast, 0);
    chk({tag, "_tuser"}, tx_axis_tuser, 0);
    chk({tag, "_tdata"}, tx_axis_tdata, 0);
    chk({tag, "_tkeep"}, tx_axis_tkeep, 0);
    chk({tag, "_rx_tready"}, rx_axis_tready, 0);
    chk({tag, "_done"}, FrmDone, 0);
    chk({tag, "_len"}, FrmLen, 0);
    chk({tag, "_err"}, FrmErr, 0);
    chk({tag, "_good"}, GoodFrm_Cnt, 0);
    chk({tag, "_bad"}, BadFrm_Cnt, 0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge axis_uclk);
    Rst_n = 1'b1;
    #1 chk({tag, "_rdy_pre_edge"}, rx_axis_tready, 0);
    @(posedge axis_uclk); #1;
    chk({tag, "_rdy_post_edge"}, rx_axis_tready, 1);
  endtask

  initial begin
    logic [18:0] s;
    int          nb, r;

    tbl[0] = '{4,    -1, 16'h0000, 16'h00FF, 16'd56,    3'b010};
    tbl[1] = '{5,    -1, 16'h0000, 16'hFFFF, 16'd80,    3'b000};
    tbl[2] = '{6,     1, 16'h00FF, 16'hFFFF, 16'd88,    3'b001};
    tbl[3] = '{601,  -1, 16'h0000, 16'hFFFF, 16'd9616,  3'b100};
    tbl[4] = '{4100, -1, 16'h0000, 16'hFFFF, 16'hFFFF,  3'b100};
    tbl[5] = '{4,    -1, 16'h0000, 16'hFFFF, 16'd64,    3'b000};
    tbl[6] = '{600,  -1, 16'h0000, 16'hFFFF, 16'd9600,  3'b000};
    tbl[7] = '{1,    -1, 16'h0000, 16'h0000, 16'd0,     3'b011};
    tbl[8] = '{4,    -1, 16'h0000, 16'h7FFF, 16'd63,    3'b010};
    tbl[9] = '{601,  -1, 16'h0000, 16'h0001, 16'd9601,  3'b100};

    repeat (3) @(posedge axis_uclk);
    #1 check_reset("por");
    release_reset("por");

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < tbl[v].nb; i++) frame_keep[i] = 16'hFFFF;
      if (tbl[v].bad_idx >= 0) frame_keep[tbl[v].bad_idx] = tbl[v].bad_keep;
      frame_keep[tbl[v].nb - 1] = tbl[v].last_keep;
      send_frame(tbl[v].nb, tbl[v].exp_len, tbl[v].exp_err, 1'b0);
    end
    drain();
    check_counters("table");

    // Single-beat runt: 1-cycle latency, FrmDone pulse, and clear during the FrmDone cycle.
    chk("idle_tvalid", tx_axis_tvalid, 0);
    frame_keep[0] = 16'hFFFF;
    send_frame(1, 16'd16, 3'b010, 1'b0);
    chk("latency_tvalid", tx_axis_tvalid, 1);
    chk("done_pulse", FrmDone, 1);
    CntClr = 1'b1;
    good_m = 0; bad_m = 0;
    @(posedge axis_uclk); #1;
    CntClr = 1'b0;
    chk("done_one_cycle", FrmDone, 0);
    check_counters("clr");
    @(posedge axis_uclk); #1;
    check_counters("clr_hold");

    rdy_rand = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      nb = (f % 100 == 50) ? int'($urandom_range(595, 606)) : int'($urandom_range(1, 8));
      for (int i = 0; i < nb; i++)
        frame_keep[i] = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'hFFFF;
      r = $urandom_range(0, 5);
      if (r == 0)      frame_keep[nb-1] = 16'h0000;
      else if (r == 1) frame_keep[nb-1] = 16'($urandom);
      else             frame_keep[nb-1] = 16'hFFFF;
      s = ref_status(nb);
      send_frame(nb, s[18:3], s[2:0], 1'b1);
    end
    drain();
    check_counters("random");

    // Reset with a partial frame held in the pipeline.
    rdy_rand = 1'b0; rdy_fixed = 1'b0;
    repeat (2) @(posedge axis_uclk);
    #1;
    send_beat({4{32'hA5A5_0001}}, 16'hFFFF, 1'b0, 1'b0, 0);
    send_beat({4{32'hA5A5_0002}}, 16'hFFFF, 1'b0, 1'b0, 0);
    Rst_n = 1'b0;
    exp_q.delete(); stat_q.delete(); cyc_q.delete();
    good_m = 0; bad_m = 0;
    #1 check_reset("midrst");
    rdy_fixed = 1'b1;
    repeat (2) @(posedge axis_uclk);
    release_reset("midrst");
    for (int i = 0; i < 5; i++) frame_keep[i] = 16'hFFFF;
    send_frame(5, 16'd80, 3'b000, 1'b0);
    drain();
    check_counters("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
